instr_fetch_unit: RTL and testbench
===================================

Name: instr_fetch_unit

Overview:
- Fetch stage directly upstream of pipelined_processor.
- Generates sequential PCs, issues requests to instruction memory and buffers the in-order responses in a small prefetch FIFO.
- Presents one 32-bit instruction per cycle to the processor's instruction input through a valid/ready handshake.
- Supports a single-cycle redirect (branch/jump/exception) that flushes buffered and in-flight instructions.

Parameters:
- RESET_PC, 32'h0000_0000, PC issued first after reset.
- DEPTH, 4, prefetch FIFO entries and maximum outstanding requests; power of two, 2..16.
- PC_STEP, 4, byte increment between sequential fetches.

Ports:
- clk  in  1  rising-edge clock, single clock domain.
- reset  in  1  asynchronous, active-high; clears all state.
- imem_req_valid  out  1  request to instruction memory is valid.
- imem_req_ready  in  1  memory accepts the request this cycle.
- imem_addr  out  32  byte address of the request; equals the current fetch PC.
- imem_rsp_valid  in  1  response data valid; responses return in request order, latency >= 1 cycle, unbounded.
- imem_rsp_data  in  32  instruction word.
- redirect_valid  in  1  flush and restart fetch at redirect_pc.
- redirect_pc  in  32  new fetch PC.
- instr_valid  out  1  instruction_out/pc_out valid.
- instr_ready  in  1  downstream consumes this cycle.
- instruction_out  out  32  instruction word, feeds pipelined_processor instruction_in.
- pc_out  out  32  PC of instruction_out.

Behaviour:
- Reset (async assert):
  - fetch_pc = RESET_PC; FIFO empty; inflight = 0; drop_cnt = 0.
  - imem_req_valid = 0, instr_valid = 0, instruction_out = 0, pc_out = 0.
- Issue:
  - imem_req_valid = !redirect_valid && (fifo_count + inflight < DEPTH).
  - This is a credit rule: the FIFO can never overflow, so there is no response back-pressure.
  - A request is accepted when imem_req_valid && imem_req_ready; fetch_pc += PC_STEP (32-bit wrap, 0xFFFF_FFFC -> 0x0).
  - The issued PC is pushed into a PC tag queue of DEPTH entries.
- Response:
  - Each imem_rsp_valid decrements inflight.
  - If drop_cnt > 0: the response is discarded, drop_cnt decrements, and its tag is popped.
  - Otherwise {tag PC, data} is written to the FIFO.
- Output:
  - FIFO head is registered; instr_valid = (fifo_count != 0).
  - A response written in cycle N is visible at instr_valid in cycle N+1; there is no combinational bypass.
  - Pop on instr_valid && instr_ready.
  - instruction_out/pc_out hold stable while instr_valid && !instr_ready.
- Simultaneous push and pop with the FIFO full or empty:
  - Both are legal; fifo_count is unchanged.
  - A pop from empty or a push beyond full cannot occur by construction; the bench asserts this.
- Redirect (cycle R):
  - FIFO cleared (count 0, instr_valid = 0 in R+1); the pop in cycle R has no effect.
  - No request issued in R.
  - Any response arriving in R is discarded.
  - drop_cnt = inflight - imem_rsp_valid; inflight keeps counting those requests until they return.
  - fetch_pc = redirect_pc at R+1; first new request at R+1 if credits allow.
- Back-to-back redirects: the last one wins; drop_cnt is recomputed each cycle from the total inflight.
- Reset mid-operation: all counters and the FIFO clear immediately.
  - Responses to pre-reset requests arriving after reset are a system error and are outside the spec.
- Credit counters are log2(DEPTH)+1 bits wide; inflight <= DEPTH always.

Decomposition:
- pipe_pkg (shared with pipelined_processor):
  - XLEN = 32, INSTR_W = 32.
  - Opcode field [31:26], rd [25:21], rs1 [20:16], rs2 [15:11], imm [15:0].
  - Opcode constants OP_ADD = 6'b000000, OP_SUB = 6'b000001, OP_LOAD = 6'b000010.
  - A fetch_entry_t struct {pc, instr}.
- Sub-module sync_fifo:
  - Parameterised WIDTH and DEPTH, with flush, push, pop, count, head.
  - Instantiated twice: the 64-bit instruction FIFO and the 32-bit PC tag queue.

Test Plan:
- Reset release with mem latency 1, ready always 1:
  - Requests go to 0x0, 0x4, 0x8 on consecutive cycles.
  - Words 0x00221800 (ADD R1,R2,R3), 0x04812800 (SUB R4,R1,R5) and 0x08C70064 (LOAD R6,100(R7)) return.
  - They appear in order on instruction_out with pc_out 0x0/0x4/0x8; the first has instr_valid 2 cycles after its request.
- instr_ready held 0 for 10 cycles:
  - After 4 requests imem_req_valid drops to 0; fifo_count = 4; outputs stable.
  - On release, 4 pops occur and issue resumes.
- Mem latency 3 with imem_req_ready toggling 1,0,1,0:
  - imem_addr stays constant while not accepted; there are no duplicate or skipped PCs.
- Redirect to 0x100 with 2 in flight and 2 buffered:
  - instr_valid = 0 next cycle; the 2 late responses are dropped.
  - The first delivered pc_out is 0x100.
- Redirect coincident with a response and a pop: the response is discarded, drop_cnt = inflight-1, and no stale instruction is delivered.
- RESET_PC = 0xFFFF_FFF8:
  - PCs run FFF8, FFFC, 0x0.
  - Async reset asserted mid-stream clears instr_valid and imem_req_valid within the same cycle.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared definitions for the fetch stage and the pipelined processor.
// Contents: datapath widths, instruction field positions, opcode constants,
// the fetch_entry_t {pc, instr} record carried through the prefetch FIFO,
// and a small opcode-extraction helper.
package pipe_pkg;

    localparam int XLEN    = 32;
    localparam int INSTR_W = 32;

    // Instruction field positions
    localparam int OPC_MSB = 31;
    localparam int OPC_LSB = 26;
    localparam int RD_MSB  = 25;
    localparam int RD_LSB  = 21;
    localparam int RS1_MSB = 20;
    localparam int RS1_LSB = 16;
    localparam int RS2_MSB = 15;
    localparam int RS2_LSB = 11;
    localparam int IMM_MSB = 15;
    localparam int IMM_LSB = 0;

    localparam logic [5:0] OP_ADD  = 6'b000000;
    localparam logic [5:0] OP_SUB  = 6'b000001;
    localparam logic [5:0] OP_LOAD = 6'b000010;

    typedef struct packed {
        logic [XLEN-1:0]    pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;

    function automatic logic [5:0] get_opcode(input logic [INSTR_W-1:0] instr);
        return instr[OPC_MSB:OPC_LSB];
    endfunction

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Bus bundle around the fetch unit.
// Signals: instruction-memory request (valid/ready/addr), in-order memory
// response (valid/data), redirect (valid/pc) and the instruction output
// handshake (valid/ready/instruction/pc).
// Modports: master = fetch unit side, slave = memory/processor environment.
interface instr_fetch_unit_if;
    import pipe_pkg::*;

    logic               imem_req_valid;
    logic               imem_req_ready;
    logic [XLEN-1:0]    imem_addr;
    logic               imem_rsp_valid;
    logic [INSTR_W-1:0] imem_rsp_data;
    logic               redirect_valid;
    logic [XLEN-1:0]    redirect_pc;
    logic               instr_valid;
    logic               instr_ready;
    logic [INSTR_W-1:0] instruction_out;
    logic [XLEN-1:0]    pc_out;

    modport master (
        output imem_req_valid, imem_addr, instr_valid, instruction_out, pc_out,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
               redirect_valid, redirect_pc, instr_ready
    );

    modport slave (
        input  imem_req_valid, imem_addr, instr_valid, instruction_out, pc_out,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data,
               redirect_valid, redirect_pc, instr_ready
    );

endinterface

// File: rtl/instr_fetch_unit_sync_fifo.sv
// sync_fifo: small synchronous FIFO built as a shift register so the head
// entry is always a flop (entry 0), giving a registered read port.
// Ports:
//   clk, reset    clock, asynchronous active-high reset (clears entries)
//   flush_i       empties the FIFO (count -> 0)
//   push_i/push_data_i  write an entry at the tail
//   pop_i         drop the head entry
//   count_o       occupancy, 0..DEPTH
//   head_o        oldest entry (stale when count_o == 0)
// Simultaneous push and pop are legal at any occupancy, including full.
module sync_fifo
    import pipe_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush_i,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         push_data_i,
    input  logic                     pop_i,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic [WIDTH-1:0]         head_o
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] FULL_C = CW'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [CW-1:0]    count_q;
    logic [CW-1:0]    count_d;
    logic [CW-1:0]    wr_idx_s;
    logic             pop_s;
    logic             push_s;

    // Next-state: shift on pop, write the tail slot on push
    always_comb begin
        mem_d    = mem_q;
        count_d  = count_q;
        pop_s    = pop_i && (count_q != {CW{1'b0}});
        push_s   = push_i && ((count_q != FULL_C) || pop_s);
        // With a pop the tail moves down one slot before the write lands.
        wr_idx_s = pop_s ? (count_q - CW'(1)) : count_q;
        for (int i = 0; i < DEPTH; i++) begin
            if (push_s && (CW'(i) == wr_idx_s)) begin
                mem_d[i] = push_data_i;
            end else if (pop_s && (i < DEPTH - 1)) begin
                mem_d[i] = mem_q[(i + 1) % DEPTH];
            end else begin
                mem_d[i] = mem_q[i];
            end
        end
        if (flush_i) begin
            count_d = {CW{1'b0}};
        end else begin
            count_d = count_q + CW'(push_s) - CW'(pop_s);
        end
    end

    // Storage and occupancy registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= {CW{1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= {WIDTH{1'b0}};
            end
        end else begin
            count_q <= count_d;
            mem_q   <= mem_d;
        end
    end

    assign count_o = count_q;
    assign head_o  = mem_q[0];

endmodule

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: fetch stage feeding pipelined_processor.
// Generates sequential PCs, requests instruction memory under a credit rule
// (buffered + in-flight never exceeds DEPTH, so responses need no
// back-pressure), tags in-order responses with their PC and buffers them in
// a prefetch FIFO whose registered head drives the instruction output.
// A redirect flushes the FIFO, suppresses issue for that cycle, and marks all
// still-outstanding requests to be dropped when they return.
// Ports:
//   clk, reset  clock, asynchronous active-high reset
//   bus         instr_fetch_unit_if.master (memory req/rsp, redirect,
//               instruction output handshake)
module instr_fetch_unit
    import pipe_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] PC_STEP  = 32'd4
) (
    input  logic                clk,
    input  logic                reset,
    instr_fetch_unit_if.master  bus
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW:0] DEPTH_C = (CW + 1)'(DEPTH);

    logic [XLEN-1:0] fetch_pc_q;
    logic [XLEN-1:0] fetch_pc_d;
    logic [CW-1:0]   drop_cnt_q;
    logic [CW-1:0]   drop_cnt_d;
    logic [CW-1:0]   fifo_count_s;
    logic [CW-1:0]   inflight_s;
    logic [CW:0]     credit_use_s;
    logic            req_valid_s;
    logic            accept_s;
    logic            rsp_s;
    logic            keep_rsp_s;
    logic            pop_s;
    logic            redirect_s;
    logic [XLEN-1:0] tag_head_s;
    fetch_entry_t    push_entry_s;
    fetch_entry_t    head_entry_s;

    // Issue, response-routing and counter next-state logic
    always_comb begin
        redirect_s   = bus.redirect_valid;
        rsp_s        = bus.imem_rsp_valid;
        credit_use_s = {1'b0, fifo_count_s} + {1'b0, inflight_s};
        // Gating with reset keeps the request low while reset is held.
        req_valid_s  = !reset && !redirect_s && (credit_use_s < DEPTH_C);
        accept_s     = req_valid_s && bus.imem_req_ready;
        keep_rsp_s   = rsp_s && !redirect_s && (drop_cnt_q == {CW{1'b0}});
        pop_s        = (fifo_count_s != {CW{1'b0}}) && bus.instr_ready && !redirect_s;
        push_entry_s.pc    = tag_head_s;
        push_entry_s.instr = bus.imem_rsp_data;

        if (redirect_s) begin
            fetch_pc_d = bus.redirect_pc;
        end else if (accept_s) begin
            fetch_pc_d = fetch_pc_q + PC_STEP;
        end else begin
            fetch_pc_d = fetch_pc_q;
        end

        // Everything still outstanding after this cycle belongs to the old
        // stream; recomputed from the live total on every redirect.
        if (redirect_s) begin
            drop_cnt_d = inflight_s - CW'(rsp_s);
        end else if (rsp_s && (drop_cnt_q != {CW{1'b0}})) begin
            drop_cnt_d = drop_cnt_q - CW'(1);
        end else begin
            drop_cnt_d = drop_cnt_q;
        end
    end

    // Fetch PC and drop counter registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_pc_q <= RESET_PC;
            drop_cnt_q <= {CW{1'b0}};
        end else begin
            fetch_pc_q <= fetch_pc_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    // PC tag queue: one entry per outstanding request, so its occupancy is
    // the in-flight count. Never flushed: dropped responses still retire tags.
    sync_fifo #(
        .WIDTH (XLEN),
        .DEPTH (DEPTH)
    ) u_tag_q (
        .clk         (clk),
        .reset       (reset),
        .flush_i     (1'b0),
        .push_i      (accept_s),
        .push_data_i (fetch_pc_q),
        .pop_i       (rsp_s),
        .count_o     (inflight_s),
        .head_o      (tag_head_s)
    );

    // Prefetch FIFO of {pc, instr}; head is a flop so outputs are registered.
    sync_fifo #(
        .WIDTH ($bits(fetch_entry_t)),
        .DEPTH (DEPTH)
    ) u_instr_fifo (
        .clk         (clk),
        .reset       (reset),
        .flush_i     (redirect_s),
        .push_i      (keep_rsp_s),
        .push_data_i (push_entry_s),
        .pop_i       (pop_s),
        .count_o     (fifo_count_s),
        .head_o      (head_entry_s)
    );

    assign bus.imem_req_valid  = req_valid_s;
    assign bus.imem_addr       = fetch_pc_q;
    assign bus.instr_valid     = (fifo_count_s != {CW{1'b0}});
    assign bus.instruction_out = head_entry_s.instr;
    assign bus.pc_out          = head_entry_s.pc;

endmodule

// File: tb/tb_instr_fetch_unit.sv
module tb_instr_fetch_unit;
    import pipe_pkg::*;

    localparam logic [31:0] RST_PC = 32'hFFFF_FFF8;
    localparam int          DEPTH  = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    instr_fetch_unit_if bus ();

    instr_fetch_unit #(
        .RESET_PC (RST_PC),
        .DEPTH    (DEPTH),
        .PC_STEP  (32'd4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct { logic [31:0] addr; int due; } mreq_t;
    typedef struct { logic [31:0] pc; bit stale; } tag_t;

    // Memory model queue and reference model state
    mreq_t       memq[$];
    tag_t        tags[$];   // outstanding requests in issue order
    logic [31:0] outq[$];   // PCs that should be visible at the output, in order
    logic [31:0] exp_pc;
    int          cyc;
    int          n_pass, n_fail, n_total;
    bit          rr, ir;
    int          lat;
    bit          obs_req, obs_iv, rsp_now, found;
    logic [31:0] obs_addr, obs_pc, obs_instr;
    logic [31:0] a_words [3];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h0000_0000: return 32'h0022_1800;
            32'h0000_0004: return 32'h0481_2800;
            32'h0000_0008: return 32'h08C7_0064;
            default:       return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        memq.delete();
        tags.delete();
        outq.delete();
        exp_pc = RST_PC;
    endtask

    // One clock cycle: drive at negedge, check 1ns later, advance model.
    task automatic cycle(input bit redir, input logic [31:0] rpc);
        bit   exp_req;
        tag_t t;
        @(negedge clk);
        bus.imem_req_ready = rr;
        bus.instr_ready    = ir;
        bus.redirect_valid = redir;
        bus.redirect_pc    = rpc;
        rsp_now            = 1'b0;
        bus.imem_rsp_data  = 32'h0;
        if (memq.size() != 0) begin
            if (memq[0].due <= cyc) begin
                rsp_now           = 1'b1;
                bus.imem_rsp_data = mem_word(memq[0].addr);
                void'(memq.pop_front());
            end
        end
        bus.imem_rsp_valid = rsp_now;
        #1;
        obs_req   = bus.imem_req_valid;
        obs_addr  = bus.imem_addr;
        obs_iv    = bus.instr_valid;
        obs_pc    = bus.pc_out;
        obs_instr = bus.instruction_out;

        exp_req = !redir && ((outq.size() + tags.size()) < DEPTH);
        chk("imem_req_valid", 32'(obs_req), 32'(exp_req));
        if (exp_req) chk("imem_addr", obs_addr, exp_pc);
        chk("instr_valid", 32'(obs_iv), 32'(outq.size() != 0));
        if (outq.size() != 0) begin
            chk("pc_out", obs_pc, outq[0]);
            chk("instruction_out", obs_instr, mem_word(outq[0]));
        end

        // memory answers whatever the DUT actually presented
        if (obs_req && rr) memq.push_back('{obs_addr, cyc + lat});

        if ((outq.size() != 0) && ir && !redir) void'(outq.pop_front());
        if (rsp_now && (tags.size() != 0)) begin
            t = tags.pop_front();
            if (!t.stale && !redir) outq.push_back(t.pc);
        end
        if (redir) begin
            outq.delete();
            foreach (tags[i]) tags[i].stale = 1'b1;
            exp_pc = rpc;
        end else if (exp_req && rr) begin
            tags.push_back('{exp_pc, 1'b0});
            exp_pc = exp_pc + 32'd4;
        end
        cyc++;
    endtask

    initial begin
        n_pass = 0; n_fail = 0; n_total = 0; cyc = 0;
        a_words[0] = 32'h0022_1800;
        a_words[1] = 32'h0481_2800;
        a_words[2] = 32'h08C7_0064;
        rr = 1'b1; ir = 1'b1; lat = 1;
        reset = 1'b1;
        bus.imem_req_ready = 1'b0; bus.imem_rsp_valid = 1'b0; bus.imem_rsp_data = 32'h0;
        bus.redirect_valid = 1'b0; bus.redirect_pc = 32'h0; bus.instr_ready = 1'b0;
        model_reset();

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk); #1;
        chk("rst_req_valid", 32'(bus.imem_req_valid), 32'd0);
        chk("rst_instr_valid", 32'(bus.instr_valid), 32'd0);
        chk("rst_instruction_out", bus.instruction_out, 32'd0);
        chk("rst_pc_out", bus.pc_out, 32'd0);
        chk("rst_addr", bus.imem_addr, RST_PC);
        @(posedge clk); #2 reset = 1'b0;

        // Latency 1, ready 1: PCs wrap FFF8, FFFC, 0; ADD/SUB/LOAD follow
        for (int k = 0; k < 7; k++) begin
            cycle(1'b0, 32'h0);
            chk("a_addr", obs_addr, RST_PC + 32'(4 * k));
            chk("a_valid_latency", 32'(obs_iv), 32'(k >= 2));
            if (k >= 2) chk("a_pc", obs_pc, RST_PC + 32'(4 * (k - 2)));
            if (k >= 4) chk("a_word", obs_instr, a_words[k - 4]);
        end

        // Downstream stall: credits run out, then drain 4 and resume issue
        ir = 1'b0;
        for (int k = 0; k < 10; k++) begin
            cycle(1'b0, 32'h0);
            if (k == 9) begin
                chk("b_req_blocked", 32'(obs_req), 32'd0);
                chk("b_valid_held", 32'(obs_iv), 32'd1);
            end
        end
        ir = 1'b1;
        for (int k = 0; k < 4; k++) begin
            cycle(1'b0, 32'h0);
            chk("b_drain_valid", 32'(obs_iv), 32'd1);
            if (k == 0) chk("b_still_full", 32'(obs_req), 32'd0);
            if (k == 1) chk("b_issue_resumed", 32'(obs_req), 32'd1);
        end

        // Latency 3 with req_ready toggling
        lat = 3;
        for (int k = 0; k < 16; k++) begin
            rr = (k % 2 == 0);
            cycle(1'b0, 32'h0);
            if (k >= 4) chk("c_req_valid", 32'(obs_req), 32'd1);
        end

        // Redirect to 0x100 with 2 in flight and 2 buffered
        rr = 1'b0; ir = 1'b1;
        repeat (8) cycle(1'b0, 32'h0);
        rr = 1'b1; ir = 1'b0; found = 1'b0;
        for (int k = 0; k < 20; k++) begin
            cycle(1'b0, 32'h0);
            if (outq.size() == 2 && tags.size() == 2) begin found = 1'b1; break; end
        end
        chk("d_setup_reached", 32'(found), 32'd1);
        cycle(1'b1, 32'h0000_0100);
        cycle(1'b0, 32'h0);
        chk("d_flushed", 32'(obs_iv), 32'd0);
        ir = 1'b1; found = 1'b0;
        for (int k = 0; k < 20; k++) begin
            cycle(1'b0, 32'h0);
            if (obs_iv) begin found = 1'b1; break; end
        end
        chk("d_first_seen", 32'(found), 32'd1);
        chk("d_first_pc", obs_pc, 32'h0000_0100);

        // Redirect coincident with a response and a pop
        lat = 2; found = 1'b0;
        for (int k = 0; k < 20; k++) begin
            cycle(1'b0, 32'h0);
            if (memq.size() != 0 && outq.size() != 0) begin
                if (memq[0].due <= cyc) begin found = 1'b1; break; end
            end
        end
        chk("e_setup_reached", 32'(found), 32'd1);
        cycle(1'b1, 32'h0000_0200);
        chk("e_rsp_in_redirect", 32'(rsp_now), 32'd1);
        cycle(1'b0, 32'h0);
        chk("e_flushed", 32'(obs_iv), 32'd0);
        found = 1'b0;
        for (int k = 0; k < 20; k++) begin
            cycle(1'b0, 32'h0);
            if (obs_iv) begin found = 1'b1; break; end
        end
        chk("e_first_seen", 32'(found), 32'd1);
        chk("e_first_pc", obs_pc, 32'h0000_0200);

        // Randomized traffic against the model
        for (int k = 0; k < 400; k++) begin
            rr  = ($urandom_range(0, 3) != 0);
            ir  = ($urandom_range(0, 2) != 0);
            lat = $urandom_range(1, 4);
            if ($urandom_range(0, 19) == 0) cycle(1'b1, $urandom & 32'hFFFF_FFFC);
            else cycle(1'b0, 32'h0);
        end

        // Async reset mid-stream, then restart at RESET_PC with wrap
        rr = 1'b1; ir = 1'b0; lat = 1;
        repeat (6) cycle(1'b0, 32'h0);
        chk("g_valid_before_reset", 32'(obs_iv), 32'd1);
        @(posedge clk); #2 reset = 1'b1;
        #1;
        chk("g_req_cleared", 32'(bus.imem_req_valid), 32'd0);
        chk("g_valid_cleared", 32'(bus.instr_valid), 32'd0);
        bus.imem_rsp_valid = 1'b0; bus.redirect_valid = 1'b0;
        model_reset();
        @(posedge clk); #2 reset = 1'b0;
        ir = 1'b1;
        for (int k = 0; k < 4; k++) begin
            cycle(1'b0, 32'h0);
            chk("g_addr", obs_addr, RST_PC + 32'(4 * k));
        end
        repeat (6) cycle(1'b0, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
